// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction-fetch stage with IF/ID pipeline register.
//            Owns the PC and keeps a single request outstanding to
//            instruction memory over a ready handshake. Honours the decode
//            stall (StallD) and the decode-stage branch redirect (PCSrcD).
//            Optional performance counters are enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic [5:0]  OpD,
   output logic [5:0]  FunctD,
   output logic        ValidD,
   output logic        FetchBusy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] BubbleCount
`endif
);

   // REQ  : request outstanding at PCF
   // HOLD : a word arrived during a stall and sits in the hold buffer
   // DROP : a redirect arrived while a request was pending; its reply is junk
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_f, pc_nxt;
   logic [31:0] instr_d, instr_nxt;
   logic [31:0] pc4_d, pc4_nxt;
   logic        valid_d, valid_nxt;
   logic [31:0] hold_instr, hold_instr_nxt;
   logic [31:0] hold_pc4, hold_pc4_nxt;
   logic [31:0] drop_target, drop_target_nxt;
   logic        load_valid;
   logic        load_bubble;

   logic [31:0] pc_plus4;
   logic [31:0] branch_tgt;
   logic        take_branch;

   // PC+4 wraps naturally at 2^32; branch targets are forced word-aligned
   assign pc_plus4    = pc_f + 32'd4;
   assign branch_tgt  = PCBranchD & ~32'h0000_0003;
   assign take_branch = PCSrcD & ~StallD;

   // Next-state, PC and IF/ID update selection
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc_f;
      instr_nxt       = instr_d;
      pc4_nxt         = pc4_d;
      valid_nxt       = valid_d;
      hold_instr_nxt  = hold_instr;
      hold_pc4_nxt    = hold_pc4;
      drop_target_nxt = drop_target;
      load_valid      = 1'b0;
      load_bubble     = 1'b0;

      case (state)
         ST_REQ: begin
            if (StallD) begin
               // Decode frozen: park an arriving word in the hold buffer
               if (imem_ready) begin
                  hold_instr_nxt = imem_rdata;
                  hold_pc4_nxt   = pc_plus4;
                  pc_nxt         = pc_plus4;
                  state_nxt      = ST_HOLD;
               end
            end else if (PCSrcD) begin
               instr_nxt   = NOP_INSTR;
               valid_nxt   = 1'b0;
               load_bubble = 1'b1;
               if (imem_ready) begin
                  pc_nxt = branch_tgt;
               end else begin
                  // Request still pending: wait for its reply before redirecting
                  drop_target_nxt = branch_tgt;
                  state_nxt       = ST_DROP;
               end
            end else if (imem_ready) begin
               instr_nxt  = imem_rdata;
               pc4_nxt    = pc_plus4;
               valid_nxt  = 1'b1;
               load_valid = 1'b1;
               pc_nxt     = pc_plus4;
            end else begin
               instr_nxt   = NOP_INSTR;
               valid_nxt   = 1'b0;
               load_bubble = 1'b1;
            end
         end

         ST_HOLD: begin
            if (!StallD) begin
               state_nxt = ST_REQ;
               if (PCSrcD) begin
                  instr_nxt   = NOP_INSTR;
                  valid_nxt   = 1'b0;
                  load_bubble = 1'b1;
                  pc_nxt      = branch_tgt;
               end else begin
                  instr_nxt  = hold_instr;
                  pc4_nxt    = hold_pc4;
                  valid_nxt  = 1'b1;
                  load_valid = 1'b1;
               end
            end
         end

         ST_DROP: begin
            if (!StallD) begin
               instr_nxt   = NOP_INSTR;
               valid_nxt   = 1'b0;
               load_bubble = 1'b1;
            end
            // A newer redirect supersedes the saved target, even on the reply cycle
            if (take_branch) begin
               drop_target_nxt = branch_tgt;
            end
            if (imem_ready) begin
               pc_nxt    = take_branch ? branch_tgt : drop_target;
               state_nxt = ST_REQ;
            end
         end

         default: begin
            state_nxt = ST_REQ;
         end
      endcase
   end

   // State register and pipeline registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_REQ;
         pc_f        <= RESET_PC;
         instr_d     <= NOP_INSTR;
         pc4_d       <= 32'h0000_0000;
         valid_d     <= 1'b0;
         hold_instr  <= 32'h0000_0000;
         hold_pc4    <= 32'h0000_0000;
         drop_target <= 32'h0000_0000;
      end else begin
         state       <= state_nxt;
         pc_f        <= pc_nxt;
         instr_d     <= instr_nxt;
         pc4_d       <= pc4_nxt;
         valid_d     <= valid_nxt;
         hold_instr  <= hold_instr_nxt;
         hold_pc4    <= hold_pc4_nxt;
         drop_target <= drop_target_nxt;
      end
   end

   // The request is withdrawn during reset; in DROP the old PCF is still the address
   assign imem_req  = ~reset & (state != ST_HOLD);
   assign imem_addr = pc_f;
   assign FetchBusy = (state == ST_DROP);

   assign InstrD   = instr_d;
   assign PCPlus4D = pc4_d;
   assign ValidD   = valid_d;
   assign OpD      = instr_d[31:26];
   assign FunctD   = instr_d[5:0];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;

   // Wrapping counters of valid loads and bubble loads into IF/ID
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt  <= 32'h0000_0000;
         bubble_cnt <= 32'h0000_0000;
      end else begin
         if (load_valid)  fetch_cnt  <= fetch_cnt + 32'd1;
         if (load_bubble) bubble_cnt <= bubble_cnt + 32'd1;
      end
   end

   assign FetchCount  = fetch_cnt;
   assign BubbleCount = bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. Memory returns word=addr.
//            Expected IF/ID loads are queued by the stimulus; a monitor pops
//            and compares whenever decode receives a new valid instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        StallD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic [5:0]  OpD;
   logic [5:0]  FunctD;
   logic        ValidD;
   logic        FetchBusy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] FetchCount;
   logic [31:0] BubbleCount;
`endif

   logic        rdy;
   logic        stall_q;
   int          n_cmp;
   int          n_bad;
   logic [63:0] exp_q[$];

   fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .StallD     (StallD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .OpD        (OpD),
      .FunctD     (FunctD),
      .ValidD     (ValidD),
      .FetchBusy  (FetchBusy)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCount (FetchCount),
      .BubbleCount(BubbleCount)
`endif
   );

   // Instruction memory: word equals its address, ready under bench control
   assign imem_rdata = imem_addr;
   assign imem_ready = rdy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge, then return at the falling edge
   task automatic cyc(input logic r, input logic rd, input logic st,
                      input logic ps, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      reset     = r;
      rdy       = rd;
      StallD    = st;
      PCSrcD    = ps;
      PCBranchD = tgt;
      @(negedge clk);
   endtask

   // Decode takes a new word only when it was not stalled in the previous cycle
   always @(posedge clk) stall_q <= StallD;

   // Monitor: compare each newly loaded valid instruction against the queue
   always @(negedge clk) begin
      if (!reset && ValidD && !stall_q) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got instr %h pc4 %h, expected nothing", InstrD, PCPlus4D);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("sb_instr", InstrD, e[63:32]);
            chk("sb_pc4", PCPlus4D, e[31:0]);
         end
      end
   end

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b1;
      rdy       = 1'b0;
      StallD    = 1'b0;
      PCSrcD    = 1'b0;
      PCBranchD = 32'h0;
      stall_q   = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", InstrD, 32'h0);
      chk("rst_pc4", PCPlus4D, 32'h0);
      chk("rst_valid", {31'd0, ValidD}, 32'd0);
      chk("rst_busy", {31'd0, FetchBusy}, 32'd0);

      // Streaming, then ready low three cycles on 0x8
      exp_q.push_back({32'h0, 32'h4});
      exp_q.push_back({32'h4, 32'h8});
      exp_q.push_back({32'h8, 32'hC});
      cyc(0, 1, 0, 0, 0);   chk("a1_req", {31'd0, imem_req}, 32'd1); chk("a1_addr", imem_addr, 32'h0);
      cyc(0, 1, 0, 0, 0);   chk("a2_addr", imem_addr, 32'h4);
      cyc(0, 0, 0, 0, 0);   chk("a3_addr", imem_addr, 32'h8);
      cyc(0, 0, 0, 0, 0);   chk("a4_addr", imem_addr, 32'h8); chk("a4_valid", {31'd0, ValidD}, 32'd0);
                            chk("a4_instr", InstrD, 32'h0);
      cyc(0, 0, 0, 0, 0);   chk("a5_addr", imem_addr, 32'h8); chk("a5_valid", {31'd0, ValidD}, 32'd0);
      cyc(0, 1, 0, 0, 0);   chk("a6_addr", imem_addr, 32'h8); chk("a6_valid", {31'd0, ValidD}, 32'd0);

      // Stall two cycles while 0xC returns
      exp_q.push_back({32'hC, 32'h10});
      cyc(0, 1, 1, 0, 0);   chk("a7_addr", imem_addr, 32'hC);
      cyc(0, 1, 1, 0, 0);   chk("a8_req", {31'd0, imem_req}, 32'd0); chk("a8_instr", InstrD, 32'h8);
      cyc(0, 1, 0, 0, 0);   chk("a9_req", {31'd0, imem_req}, 32'd0); chk("a9_instr", InstrD, 32'h8);
      cyc(0, 1, 0, 0, 0);   chk("a10_req", {31'd0, imem_req}, 32'd1); chk("a10_addr", imem_addr, 32'h10);

      // Redirect to 0x40 while 0x14 is pending
      exp_q.push_back({32'h10, 32'h14});
      exp_q.push_back({32'h40, 32'h44});
      cyc(0, 0, 0, 1, 32'h40); chk("a11_addr", imem_addr, 32'h14); chk("a11_busy", {31'd0, FetchBusy}, 32'd0);
      cyc(0, 0, 0, 0, 0);   chk("a12_busy", {31'd0, FetchBusy}, 32'd1); chk("a12_addr", imem_addr, 32'h14);
                            chk("a12_req", {31'd0, imem_req}, 32'd1); chk("a12_valid", {31'd0, ValidD}, 32'd0);
      cyc(0, 1, 0, 0, 0);   chk("a13_busy", {31'd0, FetchBusy}, 32'd1); chk("a13_valid", {31'd0, ValidD}, 32'd0);
      cyc(0, 1, 0, 0, 0);   chk("a14_addr", imem_addr, 32'h40); chk("a14_busy", {31'd0, FetchBusy}, 32'd0);
                            chk("a14_valid", {31'd0, ValidD}, 32'd0);

      // Redirect under stall is ignored
      exp_q.push_back({32'h44, 32'h48});
      exp_q.push_back({32'h48, 32'h4C});
      cyc(0, 1, 1, 1, 32'h80); chk("a15_addr", imem_addr, 32'h44);
      cyc(0, 1, 0, 0, 0);   chk("a16_req", {31'd0, imem_req}, 32'd0); chk("a16_instr", InstrD, 32'h40);
      cyc(0, 1, 0, 0, 0);   chk("a17_addr", imem_addr, 32'h48);

      // Redirect with ready; low target bits dropped
      exp_q.push_back({32'h100, 32'h104});
      cyc(0, 1, 0, 1, 32'h103); chk("a18_addr", imem_addr, 32'h4C);
      cyc(0, 1, 0, 0, 0);   chk("a19_addr", imem_addr, 32'h100); chk("a19_valid", {31'd0, ValidD}, 32'd0);

      // PC wrap at the top of the address space
      exp_q.push_back({32'hFFFF_FFFC, 32'h0});
      exp_q.push_back({32'h0, 32'h4});
      cyc(0, 1, 0, 1, 32'hFFFF_FFFC); chk("a20_addr", imem_addr, 32'h104);
      cyc(0, 1, 0, 0, 0);   chk("a21_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(0, 1, 0, 0, 0);   chk("a22_addr", imem_addr, 32'h0);
                            chk("a22_op", {26'd0, OpD}, 32'h3F); chk("a22_funct", {26'd0, FunctD}, 32'h3C);

      // Reset while in DROP
      cyc(0, 0, 0, 1, 32'h200); chk("a23_addr", imem_addr, 32'h4);
      cyc(1, 0, 0, 0, 0);   chk("a24_busy", {31'd0, FetchBusy}, 32'd1); chk("a24_req", {31'd0, imem_req}, 32'd0);
      cyc(1, 0, 0, 0, 0);   chk("a25_valid", {31'd0, ValidD}, 32'd0); chk("a25_instr", InstrD, 32'h0);
                            chk("a25_addr", imem_addr, 32'h0); chk("a25_busy", {31'd0, FetchBusy}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
                            chk("a25_fcnt", FetchCount, 32'h0); chk("a25_bcnt", BubbleCount, 32'h0);
`endif
      exp_q.push_back({32'h0, 32'h4});
      cyc(0, 1, 0, 0, 0);   chk("a26_req", {31'd0, imem_req}, 32'd1); chk("a26_addr", imem_addr, 32'h0);
      cyc(0, 0, 0, 0, 0);   chk("a27_addr", imem_addr, 32'h4);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      chk("sb_left", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the decode-stage control unit. It owns the PC and issues single-outstanding requests to instruction memory over a ready handshake. It delivers the instruction to decode as InstrD, with OpD and FunctD split out for the control unit. It honours the decode stall (StallD) and the branch redirect (PCSrcD/PCBranchD) produced in decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected on bubbles and flushes.

- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- StallD  in  1  hazard unit: hold IF/ID contents and PC.
- PCSrcD  in  1  branch taken in decode; ignored while StallD=1.
- PCBranchD  in  32  branch target; valid when PCSrcD=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals PCF, or the held address while in DROP.
- imem_ready  in  1  response strobe; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- OpD  out  6  InstrD[31:26].
- FunctD  out  6  InstrD[5:0].
- ValidD  out  1  InstrD holds a real instruction (0 = bubble).
- FetchBusy  out  1  high while in DROP (debug/hazard visibility).

## Operation
- Reset state:
  - PCF=RESET_PC; state=REQ.
  - InstrD=NOP_INSTR; PCPlus4D=0; ValidD=0; hold buffer cleared.
  - imem_req=0 in the reset cycle only.
- Handshake:
  - imem_req and imem_addr stay stable until imem_ready=1 is sampled.
  - One request outstanding at a time.
  - imem_ready while imem_req=0 is ignored.
- State REQ (imem_req=1):
  - ready, !StallD, !PCSrcD: IF/ID ← {imem_rdata, PCF+4, valid}; PCF ← PCF+4.
  - ready, StallD: IF/ID held; hold buffer ← {imem_rdata, PCF+4}; PCF ← PCF+4; go to HOLD.
  - !ready, !StallD: IF/ID ← bubble (NOP_INSTR, ValidD=0).
  - !ready, StallD: IF/ID held.
  - PCSrcD (with !StallD) and ready: discard rdata; IF/ID ← bubble; PCF ← PCBranchD; stay in REQ.
  - PCSrcD (with !StallD) and !ready: IF/ID ← bubble; saved target ← PCBranchD; go to DROP.
- State HOLD (imem_req=0):
  - StallD=1: everything held.
  - StallD falls: IF/ID ← hold buffer, valid; go to REQ.
  - PCSrcD with !StallD: buffer discarded; IF/ID ← bubble; PCF ← PCBranchD; go to REQ.
- State DROP (imem_req=1, imem_addr = old PCF, FetchBusy=1):
  - On ready: rdata discarded; PCF ← saved target; go to REQ.
  - IF/ID receives bubbles unless StallD=1.
  - A further PCSrcD overwrites the saved target.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Low bits: PCBranchD[1:0] are forced to 0.

## Timing
- Fetch latency: a word accepted (ready) in cycle n appears on InstrD in cycle n+1.
- Throughput: 1 instruction/cycle with imem_ready tied high and no stalls.
- Redirect: the target is requested in the cycle after PCSrcD, or in the cycle after the DROP response when a request was pending. Its instruction reaches decode at the earliest 2 cycles after PCSrcD.
- Stall release from HOLD: the buffered instruction reaches decode in the cycle after StallD falls. The next request issues in that same cycle.
- Reset mid-operation: takes effect at the next edge, abandoning any outstanding request. Memory must tolerate a request withdrawn without ready.
- OpD and FunctD are combinational slices of the IF/ID register; they add no latency.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs FetchCount[31:0] and BubbleCount[31:0], both reset to 0 and wrapping.
  - FetchCount increments on every word loaded into IF/ID as valid.
  - BubbleCount increments on every cycle a bubble is loaded into IF/ID.
- FETCH_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then ready tied high, memory word=addr: InstrD sequence 0x0,0x4,0x8 on consecutive cycles from cycle 2 after reset; PCPlus4D = word+4; ValidD=1.
- ready low 3 cycles on addr 0x8: 3 bubbles (ValidD=0, InstrD=0); imem_addr held at 0x8; word 0x8 lands the cycle after ready.
- StallD high 2 cycles while 0xC is returned: InstrD holds 0x8; no imem_req in HOLD; 0xC on InstrD the cycle after release; next request is 0x10.
- PCSrcD=1 with PCBranchD=0x40 while a request to 0x14 is pending with ready low: FetchBusy=1; 0x14 response discarded; next request 0x40; InstrD=0x40 reached with no 0x14 ever valid.
- PCSrcD=1 with StallD=1: ignored; PC continues sequentially.
- Reset asserted mid-DROP: next cycle PCF=RESET_PC, ValidD=0; with FETCH_PERF_CNT_EN, both counters read 0.
